// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// datapath mux selects, ALU classes and the decoded control word.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] SrcBRegB   = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  typedef struct packed {
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic       i_or_d;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OpRType, OpLw, OpSw, OpBeq, OpAddi, OpJ: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Moore control-word decoder: maps the current state to all datapath controls.
module mc_output_decoder
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
      end
      StDecode: ctrl_o.alu_src_b = SrcBImmSh2;
      StMemAdr, StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
      end
      StMemRd: ctrl_o.i_or_d = 1'b1;
      StMemWr: begin
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMemWb: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StAddiWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StAluWb: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StExecute: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StBranch: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_op     = AluOpSub;
        ctrl_o.pc_src     = PcSrcAluOut;
        ctrl_o.branch     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_src     = PcSrcJump;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller: state register, next-state logic and the
// pc_en gate; control words come from mc_output_decoder.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic       i_or_d_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] alu_op_o,
  output logic       ir_write_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic       pc_en_o,
  output logic       instr_done_o,
  output logic       illegal_op_o,
  output logic [3:0] state_dbg_o
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (opcode_i == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  mc_output_decoder u_decoder (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Selects already sit at FETCH values in reset; only the enables need masking.
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign pc_src_o     = ctrl.pc_src;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign i_or_d_o     = ctrl.i_or_d;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_op_o     = ctrl.alu_op;
  assign branch_o     = ctrl.branch;
  assign ir_write_o   = ctrl.ir_write & rst_n;
  assign mem_write_o  = ctrl.mem_write & rst_n;
  assign reg_write_o  = ctrl.reg_write & rst_n;
  assign pc_write_o   = ctrl.pc_write & rst_n;
  assign pc_en_o      = (ctrl.pc_write | (ctrl.branch & zero_i)) & rst_n;
  assign instr_done_o = ctrl.instr_done & rst_n;
  assign illegal_op_o = rst_n & (state_q == StDecode) & ~is_legal_op(opcode_i);
  assign state_dbg_o  = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction opcode from the instruction register; stable from DECODE onward.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 alu_src_b  output  2  select for the 4:1 ALU-B datapath mux: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-007 pc_src  output  2  select for the 4:1 next-PC datapath mux: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-008 alu_src_a, i_or_d, reg_dst, mem_to_reg  output  1 each  2:1 datapath selects.
REQ-009 alu_op  output  2  ALU decoder class: 00 add, 01 sub, 10 use funct.
REQ-010 ir_write, mem_write, reg_write, pc_write, branch  output  1 each  write/branch enables.
REQ-011 pc_en  output  1  pc_write OR (branch AND zero).
REQ-012 instr_done  output  1  single-cycle pulse in the final state of each instruction.
REQ-013 illegal_op  output  1  single-cycle pulse when DECODE sees an unsupported opcode.
REQ-014 state_dbg  output  4  current state encoding.

Function
REQ-015 States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH next cycle with all enables 0.
REQ-016 Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
REQ-017 Transitions: FETCH->DECODE; DECODE->MEMADR (LW/SW), EXECUTE (R), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J), FETCH (any other); MEMADR->MEMRD (LW) / MEMWR (SW); MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-018 Outputs are Moore (state only) except pc_en; every output not listed for a state is 0.
REQ-019 FETCH: ir_write=1, pc_write=1, alu_src_b=01.
REQ-020 DECODE: alu_src_b=11.
REQ-021 MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
REQ-022 MEMRD: i_or_d=1. MEMWR: i_or_d=1, mem_write=1.
REQ-023 MEMWB: mem_to_reg=1, reg_write=1. ADDIWB: reg_write=1. ALUWB: reg_dst=1, reg_write=1.
REQ-024 EXECUTE: alu_src_a=1, alu_op=10.
REQ-025 BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1.
REQ-026 JUMP: pc_src=10, pc_write=1.
REQ-027 Cycle counts from FETCH entry to the next FETCH: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
REQ-028 instr_done=1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP; illegal_op=1 in DECODE with an unsupported opcode; the two pulses never coincide.
REQ-029 opcode is sampled only in DECODE and MEMADR; changes in other states have no effect.

Reset
REQ-030 rst_n low asynchronously forces state to FETCH, including mid-instruction.
REQ-031 While rst_n is low, ir_write, pc_write, pc_en, mem_write, reg_write, instr_done and illegal_op are forced to 0; selects take their FETCH values (alu_src_b=01, all others 0).
REQ-032 The first rising edge after rst_n deassertion executes FETCH.

Structure
REQ-033 Shared package mc_pkg: state codes, opcode constants, alu_op and mux-select encodings; the datapath uses the same select constants.
REQ-034 Sub-module mc_output_decoder: a combinational state-to-control-word decoder; the top holds the state register, the next-state logic and the pc_en gate.

Verification
REQ-035 Reset pulse mid-MEMRD, then release -> state_dbg=0, mem_write=0 and reg_write=0 during reset; DECODE on the 2nd edge after release.
REQ-036 opcode=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done at cycle 5.
REQ-037 opcode=101011 -> states 0,1,2,5,0; mem_write=1 and i_or_d=1 only in state 5.
REQ-038 opcode=000100 with zero=1, then zero=0 -> pc_en=1 in BRANCH with pc_src=01, then pc_en=0 in BRANCH.
REQ-039 opcode=000010 -> states 0,1,11,0; pc_src=10 and pc_en=1 in JUMP.
REQ-040 opcode=111111 -> states 0,1,0; illegal_op pulse in DECODE; no write enable asserted after FETCH.
